// File: rtl/joystick_spi_reader.sv
// rtl/joystick_spi_reader.sv - PmodJSTK SPI mode-0 poller producing quantised X/Y and buttons
module joystick_spi_reader #(
    parameter int SCLK_HALF   = 50,
    parameter int SS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1500,
    parameter int POLL_CYCLES = 1000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] Led,
    input  logic       MISO,
    output logic       SS,
    output logic       SCLK,
    output logic       MOSI,
    output logic [3:0] Joystick_data,
    output logic [3:0] Joy_Y,
    output logic [2:0] Buttons,
    output logic       Data_Valid
);

    localparam int WAIT_MAX = (POLL_CYCLES > SS_SETUP)
                            ? ((POLL_CYCLES > BYTE_GAP) ? POLL_CYCLES : BYTE_GAP)
                            : ((SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP);
    localparam int WAIT_W  = $clog2(WAIT_MAX + 1);
    localparam int PHASE_W = $clog2(2 * SCLK_HALF + 1);

    localparam logic [WAIT_W-1:0]  POLL_LAST  = WAIT_W'(POLL_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  SETUP_LAST = WAIT_W'(SS_SETUP - 1);
    localparam logic [WAIT_W-1:0]  GAP_LAST   = WAIT_W'(BYTE_GAP - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(SCLK_HALF - 1);
    localparam logic [PHASE_W-1:0] BIT_LAST   = PHASE_W'(2 * SCLK_HALF - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [PHASE_W-1:0]  phase_cnt;
    logic [2:0]          bit_idx;
    logic [2:0]          byte_idx;
    logic [7:0]          tx_byte;
    logic [7:0]          rx_sr;
    logic [3:0]          x_q;
    logic [3:0]          y_q;
    logic [7:0]          first_byte;

    assign first_byte = {6'b100000, Led};

    // Only X[9:6] and Y[9:6] are kept; the remaining received bits are dropped as they arrive.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            phase_cnt     <= '0;
            bit_idx       <= 3'd7;
            byte_idx      <= 3'd0;
            tx_byte       <= 8'h00;
            rx_sr         <= 8'h00;
            x_q           <= 4'd0;
            y_q           <= 4'd0;
            SS            <= 1'b1;
            SCLK          <= 1'b0;
            MOSI          <= 1'b0;
            Joystick_data <= 4'd8;
            Joy_Y         <= 4'd8;
            Buttons       <= 3'd0;
            Data_Valid    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    SS   <= 1'b1;
                    SCLK <= 1'b0;
                    MOSI <= 1'b0;
                    if (wait_cnt == POLL_LAST) begin
                        wait_cnt <= '0;
                        SS       <= 1'b0;
                        state    <= ST_SETUP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (wait_cnt == SETUP_LAST) begin
                        wait_cnt  <= '0;
                        phase_cnt <= '0;
                        byte_idx  <= 3'd0;
                        bit_idx   <= 3'd7;
                        tx_byte   <= first_byte;
                        MOSI      <= first_byte[7];
                        state     <= ST_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (phase_cnt == HALF_LAST) begin
                        SCLK      <= 1'b1;
                        rx_sr     <= {rx_sr[6:0], MISO};
                        phase_cnt <= phase_cnt + 1'b1;
                    end else if (phase_cnt == BIT_LAST) begin
                        SCLK      <= 1'b0;
                        phase_cnt <= '0;
                        if (bit_idx == 3'd0) begin
                            MOSI <= 1'b0;
                            case (byte_idx)
                                3'd0:    x_q[1:0] <= rx_sr[7:6];
                                3'd1:    x_q[3:2] <= rx_sr[1:0];
                                3'd2:    y_q[1:0] <= rx_sr[7:6];
                                3'd3:    y_q[3:2] <= rx_sr[1:0];
                                default: ;
                            endcase
                            if (byte_idx == 3'd4) begin
                                SS            <= 1'b1;
                                Joystick_data <= x_q;
                                Joy_Y         <= y_q;
                                Buttons       <= rx_sr[2:0];
                                Data_Valid    <= 1'b1;
                                state         <= ST_DONE;
                            end else begin
                                wait_cnt <= '0;
                                state    <= ST_GAP;
                            end
                        end else begin
                            bit_idx <= bit_idx - 3'd1;
                            MOSI    <= tx_byte[bit_idx - 3'd1];
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    SCLK <= 1'b0;
                    MOSI <= 1'b0;
                    if (wait_cnt == GAP_LAST) begin
                        wait_cnt  <= '0;
                        phase_cnt <= '0;
                        byte_idx  <= byte_idx + 3'd1;
                        bit_idx   <= 3'd7;
                        tx_byte   <= 8'h00;
                        MOSI      <= 1'b0;
                        state     <= ST_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    SS       <= 1'b1;
                    SCLK     <= 1'b0;
                    MOSI     <= 1'b0;
                    wait_cnt <= '0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joystick_spi_reader.sv
// tb/tb_joystick_spi_reader.sv - directed and randomized transactions against a joystick slave model
module tb_joystick_spi_reader;

    localparam int SCLK_HALF   = 2;
    localparam int SS_SETUP    = 4;
    localparam int BYTE_GAP    = 4;
    localparam int POLL_CYCLES = 200;
    localparam int TXN_LEN     = SS_SETUP + 80 * SCLK_HALF + 4 * BYTE_GAP + 1;
    localparam int BYTE2_MID   = SS_SETUP + 2 * (16 * SCLK_HALF + BYTE_GAP) + 14;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] Led;
    logic       MISO;
    logic       SS;
    logic       SCLK;
    logic       MOSI;
    logic [3:0] Joystick_data;
    logic [3:0] Joy_Y;
    logic [2:0] Buttons;
    logic       Data_Valid;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int nf;

    logic [39:0] stream = '0;
    int          slv_idx = 0;
    logic        mosi_q[$];
    int          rise_q[$];

    logic [3:0] exp_x = 4'd8;
    logic [3:0] exp_y = 4'd8;
    logic [2:0] exp_b = 3'd0;

    joystick_spi_reader #(
        .SCLK_HALF  (SCLK_HALF),
        .SS_SETUP   (SS_SETUP),
        .BYTE_GAP   (BYTE_GAP),
        .POLL_CYCLES(POLL_CYCLES)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Led          (Led),
        .MISO         (MISO),
        .SS           (SS),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .Joystick_data(Joystick_data),
        .Joy_Y        (Joy_Y),
        .Buttons      (Buttons),
        .Data_Valid   (Data_Valid)
    );

    always #5 Clk = ~Clk;

    // Joystick slave: presents MSB first, changes data after each SCLK falling edge.
    always @(negedge SS) begin
        slv_idx = 0;
        MISO    = stream[39];
        mosi_q.delete();
        rise_q.delete();
    end

    always @(negedge SCLK) begin
        if (SS === 1'b0) begin
            slv_idx = slv_idx + 1;
            MISO    = (slv_idx < 40) ? stream[39 - slv_idx] : 1'b0;
        end
    end

    always @(posedge SCLK) begin
        mosi_q.push_back(MOSI);
        rise_q.push_back(cyc + 1);
    end

    task automatic tick();
        @(negedge Clk);
        cyc = cyc + 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec = n_vec + 1;
        assert (obs === expv)
        else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_txn(input logic [9:0] x, input logic [9:0] y, input logic [2:0] btn,
                          input logic [5:0] g1, input logic [5:0] g3, input logic [1:0] led,
                          input int exp_fall, input int abort_off, output int next_fall);
        logic [4:0]  g4;
        logic [39:0] got;
        int          done_c;
        g4     = 5'($urandom);
        stream = {x[7:0], g1, x[9:8], y[7:0], g3, y[9:8], g4, btn};
        Led    = led;
        got    = '0;
        while (SS !== 1'b0 && cyc < exp_fall + 8) begin
            chk("idle", {SS, SCLK, MOSI, Data_Valid, Joystick_data, Joy_Y, Buttons},
                {4'b1000, exp_x, exp_y, exp_b});
            tick();
        end
        chk("ss_fall_cycle", 64'(cyc), 64'(exp_fall));
        if (SS !== 1'b0) begin
            next_fall = cyc + POLL_CYCLES;
            return;
        end
        done_c = exp_fall + TXN_LEN - 1;
        while (cyc < done_c) begin
            tick();
            if (cyc == exp_fall + SS_SETUP + 2) Led = ~led;
            if (abort_off != 0 && cyc == exp_fall + abort_off) begin
                chk("sclk_high_before_reset", 64'(SCLK), 64'(1));
                Reset = 1'b1;
                #1;
                exp_x = 4'd8;
                exp_y = 4'd8;
                exp_b = 3'd0;
                chk("async_reset_outputs", {SS, SCLK, MOSI, Data_Valid, Joystick_data, Joy_Y, Buttons},
                    {4'b1000, exp_x, exp_y, exp_b});
                tick();
                tick();
                chk("reset_hold_outputs", {SS, SCLK, MOSI, Data_Valid, Joystick_data, Joy_Y, Buttons},
                    {4'b1000, exp_x, exp_y, exp_b});
                Reset     = 1'b0;
                cyc       = 0;
                next_fall = POLL_CYCLES;
                return;
            end
            if (cyc < done_c)
                chk("hold_mid_txn", {SS, Data_Valid, Joystick_data, Joy_Y, Buttons},
                    {2'b00, exp_x, exp_y, exp_b});
        end
        exp_x = x[9:6];
        exp_y = y[9:6];
        exp_b = btn;
        chk("done_ss_and_strobe", {SS, Data_Valid}, 2'b11);
        chk("done_joystick_x", Joystick_data, exp_x);
        chk("done_joy_y", Joy_Y, exp_y);
        chk("done_buttons", Buttons, exp_b);
        chk("sclk_rise_count", 64'(rise_q.size()), 64'(40));
        if (rise_q.size() == 40) begin
            chk("first_sclk_rise", 64'(rise_q[0]), 64'(exp_fall + SS_SETUP + SCLK_HALF));
            chk("sclk_bit_period", 64'(rise_q[1] - rise_q[0]), 64'(2 * SCLK_HALF));
            chk("sclk_byte_gap", 64'(rise_q[8] - rise_q[7]), 64'(2 * SCLK_HALF + BYTE_GAP));
        end
        chk("mosi_bit_count", 64'(mosi_q.size()), 64'(40));
        if (mosi_q.size() == 40) begin
            for (int i = 0; i < 40; i++) got = {got[38:0], mosi_q[i]};
            chk("mosi_stream", got, {6'b100000, led, 32'h0});
        end
        tick();
        chk("strobe_one_cycle", {SS, Data_Valid, Joystick_data, Joy_Y, Buttons},
            {2'b10, exp_x, exp_y, exp_b});
        next_fall = done_c + 1 + POLL_CYCLES;
    endtask

    initial begin
        Reset = 1'b1;
        Led   = 2'b00;
        MISO  = 1'b0;
        tick();
        tick();
        tick();
        chk("reset_state", {SS, SCLK, MOSI, Data_Valid, Joystick_data, Joy_Y, Buttons},
            {4'b1000, 4'd8, 4'd8, 3'd0});
        Reset = 1'b0;
        cyc   = 0;
        nf    = POLL_CYCLES;

        do_txn(10'h3FF, 10'h000, 3'b101, 6'($urandom), 6'($urandom), 2'b11, nf, 0, nf);
        do_txn(10'h200, 10'($urandom), 3'($urandom), 6'h3F, 6'($urandom), 2'b00, nf, 0, nf);
        do_txn(10'h100, 10'($urandom), 3'($urandom), 6'($urandom), 6'h3F, 2'b10, nf, 0, nf);
        do_txn(10'h3C0, 10'($urandom), 3'($urandom), 6'($urandom), 6'($urandom), 2'b01, nf, 0, nf);
        do_txn(10'($urandom), 10'($urandom), 3'($urandom), 6'($urandom), 6'($urandom),
               2'b11, nf, BYTE2_MID, nf);
        for (int k = 0; k < 4; k++)
            do_txn(10'($urandom), 10'($urandom), 3'($urandom), 6'($urandom), 6'($urandom),
                   2'($urandom), nf, 0, nf);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
